// File: rtl/owire_defs.sv
// Shared single-wire line definitions: FSM state encodings, pulse classes, default timing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package owire_defs;

    // Receiver/transmitter line states
    typedef enum logic [1:0] {
        OW_IDLE = 2'd0,
        OW_LOW  = 2'd1,
        OW_GAP  = 2'd2
    } ow_state_e;

    // Meaning of one measured low pulse
    typedef enum logic [1:0] {
        PW_ONE   = 2'd0,
        PW_ZERO  = 2'd1,
        PW_ERR   = 2'd2,
        PW_RESET = 2'd3
    } ow_pulse_e;

    localparam int OW_DATA_W      = 8;
    localparam int OW_T_SHORT_MAX = 4;
    localparam int OW_T_LONG_MAX  = 12;
    localparam int OW_T_RESET_MIN = 40;
    localparam int OW_T_IDLE      = 64;

    // Map a low-pulse width in cycles onto its line meaning
    function automatic ow_pulse_e ow_classify(input int w, input int t_short,
                                              input int t_long, input int t_reset);
        if (w >= t_reset) begin
            return PW_RESET;
        end else if (w > t_long) begin
            return PW_ERR;
        end else if (w > t_short) begin
            return PW_ZERO;
        end
        return PW_ONE;
    endfunction

endpackage

// File: rtl/owire_sync.sv
// Two-flop line synchronizer; anything but a solid 0 (1, z, x) reads as 1; rise/fall pulses.
// Latency: raw line to line_o is 2 clocks; rise_o/fall_o are combinational off line_o.
// Backpressure: none, free-running.
module owire_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic line_m;
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // A floating or unknown line is pulled up, so only a hard 0 counts as low
    assign line_m = (line_i !== 1'b0);

    // Synchronizer chain plus a delayed copy for edge detection; idle line is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= line_m;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line_o = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/owire_rx.sv
// Single-wire pulse-width receiver: decodes low-pulse widths into LSB-first words.
// Latency: flags/data_valid rise 3 clocks after the raw line's final rising edge.
// Backpressure: one-word hold register; a word completing while unacked is dropped with overrun.
module owire_rx
    import owire_defs::*;
#(
    parameter int DATA_W      = OW_DATA_W,
    parameter int T_SHORT_MAX = OW_T_SHORT_MAX,
    parameter int T_LONG_MAX  = OW_T_LONG_MAX,
    parameter int T_RESET_MIN = OW_T_RESET_MIN,
    parameter int T_IDLE      = OW_T_IDLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              bus_reset,
    output logic              frame_err,
    output logic              overrun
);

    localparam int WID_W = $clog2(T_RESET_MIN + 1);
    localparam int IDL_W = $clog2(T_IDLE + 1);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              s_line;
    logic              s_rise;
    logic              s_fall;

    ow_state_e         state_q, state_d;
    logic [WID_W-1:0]  width_q, width_d;
    logic [IDL_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              bus_reset_q, frame_err_q, overrun_q;

    ow_pulse_e         pulse_cls;
    logic              last_bit;
    logic              idle_expire;
    logic              rx_bit;
    logic [DATA_W-1:0] word_new;

    // FSM event strobes
    logic              shift_en;
    logic              word_done;
    logic              err_evt;
    logic              rst_evt;
    logic              clr_word;
    logic              ovr_evt;

    owire_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (line_in),
        .line_o (s_line),
        .rise_o (s_rise),
        .fall_o (s_fall)
    );

    assign pulse_cls   = ow_classify(32'(width_q), T_SHORT_MAX, T_LONG_MAX, T_RESET_MIN);
    assign last_bit    = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign idle_expire = (idle_q == IDL_W'(T_IDLE - 1));
    assign rx_bit      = (pulse_cls == PW_ONE);
    assign word_new    = {rx_bit, sr_q[DATA_W-1:1]};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a pulse ends on the synchronized rising edge, gaps time out
    always_comb begin
        state_d = state_q;
        case (state_q)
            OW_IDLE: begin
                if (s_fall) state_d = OW_LOW;
            end
            OW_LOW: begin
                if (s_rise) begin
                    if ((pulse_cls == PW_ONE) || (pulse_cls == PW_ZERO)) begin
                        state_d = last_bit ? OW_IDLE : OW_GAP;
                    end else begin
                        state_d = OW_IDLE;
                    end
                end
            end
            OW_GAP: begin
                if (s_fall) begin
                    state_d = OW_LOW;
                end else if (idle_expire) begin
                    state_d = OW_IDLE;
                end
            end
            default: state_d = OW_IDLE;
        endcase
    end

    // FSM outputs: one-cycle event strobes for the datapath
    always_comb begin
        shift_en  = 1'b0;
        word_done = 1'b0;
        err_evt   = 1'b0;
        rst_evt   = 1'b0;
        clr_word  = 1'b0;
        case (state_q)
            OW_LOW: begin
                if (s_rise) begin
                    case (pulse_cls)
                        PW_ONE, PW_ZERO: begin
                            shift_en  = 1'b1;
                            word_done = last_bit;
                        end
                        PW_ERR: begin
                            err_evt  = 1'b1;
                            clr_word = 1'b1;
                        end
                        default: begin
                            rst_evt  = 1'b1;
                            clr_word = 1'b1;
                        end
                    endcase
                end
            end
            OW_GAP: begin
                if (!s_fall && idle_expire) begin
                    err_evt  = 1'b1;
                    clr_word = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath next state: width/idle counters, bit assembly and the hold register
    always_comb begin
        width_d = width_q;
        if (s_fall) begin
            width_d = WID_W'(1);
        end else if (!s_line && (width_q != WID_W'(T_RESET_MIN))) begin
            width_d = width_q + WID_W'(1);
        end

        idle_d = '0;
        if ((state_q == OW_GAP) && !s_fall && !idle_expire) begin
            idle_d = idle_q + IDL_W'(1);
        end

        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        if (clr_word || word_done) begin
            bit_cnt_d = '0;
            sr_d      = '0;
        end else if (shift_en) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            sr_d      = word_new;
        end

        data_d  = data_q;
        valid_d = valid_q;
        ovr_evt = 1'b0;
        if (word_done) begin
            if (!valid_q || data_ack) begin
                data_d  = word_new;
                valid_d = 1'b1;
            end else begin
                ovr_evt = 1'b1;
            end
        end else if (data_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // Datapath registers; status flags are registered one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q     <= '0;
            idle_q      <= '0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            bus_reset_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            width_q     <= width_d;
            idle_q      <= idle_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            bus_reset_q <= rst_evt;
            frame_err_q <= err_evt;
            overrun_q   <= ovr_evt;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign bus_reset  = bus_reset_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
